// File: rtl/avalon_s_arb_crossbar.sv
// NH-host x ND-device Avalon-MM crossbar with a registered arbiter per device.
// Unmapped addresses complete with ERR_DATA and a one-cycle decode_err pulse.
module avalon_s_arb_crossbar #(
  parameter int NH = 3,
  parameter int ND = 2,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter bit RR_EN = 1'b1,
  parameter logic [DW-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ND-1:0][AW-1:0]      devices_address_low,
  input  logic [ND-1:0][AW-1:0]      devices_address_high,
  input  logic [NH-1:0]              hosts_avn_read,
  input  logic [NH-1:0]              hosts_avn_write,
  input  logic [NH-1:0][AW-1:0]      hosts_avn_address,
  input  logic [NH-1:0][DW/8-1:0]    hosts_avn_byte_enable,
  input  logic [NH-1:0][DW-1:0]      hosts_avn_writedata,
  output logic [NH-1:0][DW-1:0]      hosts_avn_readdata,
  output logic [NH-1:0]              hosts_avn_waitrequest,
  output logic [ND-1:0]              devices_avn_read,
  output logic [ND-1:0]              devices_avn_write,
  output logic [ND-1:0][AW-1:0]      devices_avn_address,
  output logic [ND-1:0][DW/8-1:0]    devices_avn_byte_enable,
  output logic [ND-1:0][DW-1:0]      devices_avn_writedata,
  input  logic [ND-1:0][DW-1:0]      devices_avn_readdata,
  input  logic [ND-1:0]              devices_avn_waitrequest,
  output logic [NH-1:0]              decode_err
);

  localparam int HW = (NH > 1) ? $clog2(NH) : 1;
  localparam int DIW = (ND > 1) ? $clog2(ND) : 1;

  typedef enum logic {D_IDLE, D_BUSY} dst_t;
  typedef enum logic {H_IDLE, H_ERR} hst_t;

  dst_t [ND-1:0]          r_dst;
  logic [ND-1:0][HW-1:0]  r_grant;
  logic [ND-1:0][HW-1:0]  r_ptr;
  hst_t [NH-1:0]          r_hst;

  logic [NH-1:0]          w_req;
  logic [NH-1:0]          w_hit;
  logic [NH-1:0][DIW-1:0] w_tgt;
  logic [ND-1:0][NH-1:0]  w_rq;
  logic [ND-1:0]          w_any;
  logic [ND-1:0][HW-1:0]  w_win;

  // Descending scan so the lowest matching window wins on overlap.
  always_comb begin
    w_req = '0;
    w_hit = '0;
    w_tgt = '0;
    for (int h = 0; h < NH; h++) begin
      w_req[h] = hosts_avn_read[h] | hosts_avn_write[h];
      for (int d = ND - 1; d >= 0; d--) begin
        if (hosts_avn_address[h] >= devices_address_low[d] &&
            hosts_avn_address[h] <= devices_address_high[d]) begin
          w_hit[h] = 1'b1;
          w_tgt[h] = DIW'(d);
        end
      end
    end
  end

  always_comb begin
    w_rq = '0;
    for (int d = 0; d < ND; d++)
      for (int h = 0; h < NH; h++)
        w_rq[d][h] = w_req[h] & w_hit[h] & (w_tgt[h] == DIW'(d));
  end

  // First requester at or above the pointer; the pointer stays 0 in fixed mode.
  always_comb begin
    w_any = '0;
    w_win = '0;
    for (int d = 0; d < ND; d++) begin
      for (int k = NH - 1; k >= 0; k--) begin
        if (w_rq[d][(int'(r_ptr[d]) + k) % NH]) begin
          w_any[d] = 1'b1;
          w_win[d] = HW'((int'(r_ptr[d]) + k) % NH);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < ND; d++) begin
        r_dst[d]   <= D_IDLE;
        r_grant[d] <= '0;
        r_ptr[d]   <= '0;
      end
    end else begin
      for (int d = 0; d < ND; d++) begin
        case (r_dst[d])
          D_IDLE: begin
            if (w_any[d]) begin
              r_dst[d]   <= D_BUSY;
              r_grant[d] <= w_win[d];
            end
          end
          D_BUSY: begin
            if (!w_rq[d][r_grant[d]]) begin
              r_dst[d] <= D_IDLE;
            end else if (!devices_avn_waitrequest[d]) begin
              r_dst[d] <= D_IDLE;
              r_ptr[d] <= RR_EN ? HW'((int'(r_grant[d]) + 1) % NH) : '0;
            end
          end
          default: r_dst[d] <= D_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int h = 0; h < NH; h++) r_hst[h] <= H_IDLE;
    end else begin
      for (int h = 0; h < NH; h++) begin
        case (r_hst[h])
          H_IDLE:  if (w_req[h] && !w_hit[h]) r_hst[h] <= H_ERR;
          H_ERR:   r_hst[h] <= H_IDLE;
          default: r_hst[h] <= H_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    devices_avn_read        = '0;
    devices_avn_write       = '0;
    devices_avn_address     = '0;
    devices_avn_byte_enable = '0;
    devices_avn_writedata   = '0;
    for (int d = 0; d < ND; d++) begin
      if (r_dst[d] == D_BUSY) begin
        devices_avn_read[d]        = hosts_avn_read[r_grant[d]];
        devices_avn_write[d]       = hosts_avn_write[r_grant[d]];
        devices_avn_address[d]     = hosts_avn_address[r_grant[d]];
        devices_avn_byte_enable[d] = hosts_avn_byte_enable[r_grant[d]];
        devices_avn_writedata[d]   = hosts_avn_writedata[r_grant[d]];
      end
    end
  end

  always_comb begin
    hosts_avn_waitrequest = '1;
    hosts_avn_readdata    = '0;
    decode_err            = '0;
    for (int h = 0; h < NH; h++) begin
      if (r_hst[h] == H_ERR) begin
        hosts_avn_waitrequest[h] = 1'b0;
        hosts_avn_readdata[h]    = ERR_DATA;
        decode_err[h]            = 1'b1;
      end
      for (int d = 0; d < ND; d++) begin
        if (r_dst[d] == D_BUSY && r_grant[d] == HW'(h) &&
            w_rq[d][h] && !devices_avn_waitrequest[d]) begin
          hosts_avn_waitrequest[h] = 1'b0;
          hosts_avn_readdata[h]    = devices_avn_readdata[d];
        end
      end
    end
  end

endmodule

// File: tb/tb_avalon_s_arb_crossbar.sv
// Directed bench: a round-robin and a fixed-priority crossbar share one
// set of host/device stimulus and are checked against hand-computed values.
module tb_avalon_s_arb_crossbar;

  logic clk = 1'b0;
  logic rst;
  logic [1:0][31:0] lo, hi;
  logic [2:0] h_rd, h_wr;
  logic [2:0][31:0] h_addr, h_wd;
  logic [2:0][3:0] h_be;
  logic [1:0][31:0] d_rdata;
  logic [1:0] d_wait;

  logic [2:0][31:0] rr_rdata, fp_rdata;
  logic [2:0] rr_hwait, fp_hwait, rr_derr, fp_derr;
  logic [1:0] rr_drd, fp_drd, rr_dwr, fp_dwr;
  logic [1:0][31:0] rr_daddr, fp_daddr, rr_dwd, fp_dwd;
  logic [1:0][3:0] rr_dbe, fp_dbe;

  int n_chk = 0;
  int n_fail = 0;
  int rr_order[6] = '{0, 1, 2, 0, 1, 2};
  logic [2:0] erm, efm;

  always #5 clk = ~clk;

  avalon_s_arb_crossbar #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .rst(rst),
    .devices_address_low(lo), .devices_address_high(hi),
    .hosts_avn_read(h_rd), .hosts_avn_write(h_wr),
    .hosts_avn_address(h_addr), .hosts_avn_byte_enable(h_be),
    .hosts_avn_writedata(h_wd), .hosts_avn_readdata(rr_rdata),
    .hosts_avn_waitrequest(rr_hwait),
    .devices_avn_read(rr_drd), .devices_avn_write(rr_dwr),
    .devices_avn_address(rr_daddr), .devices_avn_byte_enable(rr_dbe),
    .devices_avn_writedata(rr_dwd), .devices_avn_readdata(d_rdata),
    .devices_avn_waitrequest(d_wait), .decode_err(rr_derr)
  );

  avalon_s_arb_crossbar #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .rst(rst),
    .devices_address_low(lo), .devices_address_high(hi),
    .hosts_avn_read(h_rd), .hosts_avn_write(h_wr),
    .hosts_avn_address(h_addr), .hosts_avn_byte_enable(h_be),
    .hosts_avn_writedata(h_wd), .hosts_avn_readdata(fp_rdata),
    .hosts_avn_waitrequest(fp_hwait),
    .devices_avn_read(fp_drd), .devices_avn_write(fp_dwr),
    .devices_avn_address(fp_daddr), .devices_avn_byte_enable(fp_dbe),
    .devices_avn_writedata(fp_dwd), .devices_avn_readdata(d_rdata),
    .devices_avn_waitrequest(d_wait), .decode_err(fp_derr)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    lo = {32'h0001_0000, 32'h0000_0000};
    hi = {32'h0001_FFFF, 32'h0000_FFFF};
    h_rd = '0; h_wr = '0; h_addr = '0; h_wd = '0; h_be = '1;
    d_rdata = {32'hCAFE_0001, 32'h1234_5678};
    d_wait = '0;

    @(negedge clk);
    chk("rst_hwait", 32'(rr_hwait), 32'h7);
    chk("rst_drd", 32'(rr_drd), 32'h0);
    chk("rst_derr", 32'(rr_derr), 32'h0);
    #2 rst = 1'b1;

    // three hosts hammer device 0
    step();
    h_rd = 3'b111;
    h_addr = {32'h300, 32'h200, 32'h100};
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c % 2 == 1) begin
        erm = ~(3'b001 << rr_order[c/2]);
        efm = 3'b110;
        chk("rr_daddr", rr_daddr[0], 32'(32'h100 * (rr_order[c/2] + 1)));
        chk("fp_daddr", fp_daddr[0], 32'h100);
      end else begin
        erm = 3'b111;
        efm = 3'b111;
        chk("arb_idle_drd", 32'(rr_drd), 32'h0);
      end
      chk("rr_order_wait", 32'(rr_hwait), 32'(erm));
      chk("fp_order_wait", 32'(fp_hwait), 32'(efm));
      step();
    end

    // single zero-wait read
    h_rd = 3'b001;
    h_addr[0] = 32'h10;
    @(negedge clk);
    chk("rd_c0_drd", 32'(rr_drd), 32'h0);
    chk("rd_c0_hwait", 32'(rr_hwait), 32'h7);
    step();
    @(negedge clk);
    chk("rd_c1_drd", 32'(rr_drd), 32'h1);
    chk("rd_c1_addr", rr_daddr[0], 32'h10);
    chk("rd_c1_hwait", 32'(rr_hwait), 32'h6);
    chk("rd_c1_rdata", rr_rdata[0], 32'h1234_5678);
    chk("rd_c1_rdata_idle", rr_rdata[1], 32'h0);
    step();
    h_rd = '0;
    @(negedge clk);
    chk("rd_c2_drd", 32'(rr_drd), 32'h0);

    // two hosts on two devices in parallel
    step();
    h_rd = 3'b011;
    h_addr[0] = 32'h40;
    h_addr[1] = 32'h0001_0080;
    step();
    @(negedge clk);
    chk("par_hwait", 32'(rr_hwait), 32'h4);
    chk("par_drd", 32'(rr_drd), 32'h3);
    chk("par_addr1", rr_daddr[1], 32'h0001_0080);
    chk("par_rdata0", rr_rdata[0], 32'h1234_5678);
    chk("par_rdata1", rr_rdata[1], 32'hCAFE_0001);
    step();
    h_rd = '0;

    // unmapped write
    step();
    h_wr = 3'b010;
    h_addr[1] = 32'hF000_0000;
    h_wd[1] = 32'h55;
    @(negedge clk);
    chk("de_c0_hwait", 32'(rr_hwait), 32'h7);
    chk("de_c0_derr", 32'(rr_derr), 32'h0);
    step();
    @(negedge clk);
    chk("de_c1_hwait", 32'(rr_hwait), 32'h5);
    chk("de_c1_rdata", rr_rdata[1], 32'hDEAD_BEEF);
    chk("de_c1_derr", 32'(rr_derr), 32'h2);
    chk("de_c1_fp_derr", 32'(fp_derr), 32'h2);
    chk("de_c1_dwr", 32'(rr_dwr), 32'h0);
    chk("de_c1_drd", 32'(rr_drd), 32'h0);
    step();
    h_wr = '0;
    @(negedge clk);
    chk("de_c2_derr", 32'(rr_derr), 32'h0);
    chk("de_c2_hwait", 32'(rr_hwait), 32'h7);

    // device 0 stalls while host 2 queues behind host 0
    step();
    h_rd = 3'b001;
    h_addr[0] = 32'h44;
    d_wait[0] = 1'b1;
    step();
    h_wr = 3'b100;
    h_addr[2] = 32'h20;
    h_wd[2] = 32'hA5A5_0002;
    h_be[2] = 4'hC;
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      chk("ws_drd", 32'(rr_drd), 32'h1);
      chk("ws_addr", rr_daddr[0], 32'h44);
      chk("ws_hwait", 32'(rr_hwait), 32'h7);
      step();
    end
    d_wait[0] = 1'b0;
    @(negedge clk);
    chk("ws_c4_hwait", 32'(rr_hwait), 32'h6);
    chk("ws_c4_fp_hwait", 32'(fp_hwait), 32'h6);
    chk("ws_c4_rdata", rr_rdata[0], 32'h1234_5678);
    step();
    h_rd = '0;
    @(negedge clk);
    chk("ws_c5_drd", 32'(rr_drd), 32'h0);
    chk("ws_c5_dwr", 32'(rr_dwr), 32'h0);
    chk("ws_c5_hwait", 32'(rr_hwait), 32'h7);
    step();
    @(negedge clk);
    chk("ws_c6_dwr", 32'(rr_dwr), 32'h1);
    chk("ws_c6_addr", rr_daddr[0], 32'h20);
    chk("ws_c6_wd", rr_dwd[0], 32'hA5A5_0002);
    chk("ws_c6_be", 32'(rr_dbe[0]), 32'hC);
    chk("ws_c6_hwait", 32'(rr_hwait), 32'h3);
    step();
    h_wr = '0;

    // advance the pointer, then reset in the middle of a stalled transfer
    step();
    h_rd = 3'b001;
    h_addr[0] = 32'h8;
    step();
    @(negedge clk);
    chk("pre_rst_hwait", 32'(rr_hwait), 32'h6);
    step();
    h_rd = 3'b010;
    h_addr[1] = 32'h18;
    d_wait[0] = 1'b1;
    step();
    @(negedge clk);
    chk("busy_drd", 32'(rr_drd), 32'h1);
    chk("busy_addr", rr_daddr[0], 32'h18);
    #2 rst = 1'b0;
    #1;
    chk("arst_drd", 32'(rr_drd), 32'h0);
    chk("arst_hwait", 32'(rr_hwait), 32'h7);
    chk("arst_fp_drd", 32'(fp_drd), 32'h0);
    h_rd = '0;
    d_wait = '0;
    #4 rst = 1'b1;
    step();
    h_rd = 3'b011;
    @(negedge clk);
    chk("post_c0_hwait", 32'(rr_hwait), 32'h7);
    step();
    @(negedge clk);
    chk("post_c1_hwait", 32'(rr_hwait), 32'h6);
    chk("post_c1_addr", rr_daddr[0], 32'h8);
    chk("post_c1_fp_hwait", 32'(fp_hwait), 32'h6);
    step();
    h_rd = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
